// File: rtl/axi_mem_slave.sv
// AXI4 burst slave that turns each read/write burst into sequential
// single-word accesses on a native valid/ready memory port. One transaction
// is in flight at a time; simultaneous read and write requests are served
// round-robin.
//
// Handshake semantics: every AXI channel transfers on a cycle where both
// valid and ready are high at the rising clock edge. Valid never waits on
// ready. On the native side, an access completes on a cycle where mem_valid
// and mem_ready are both high, and mem_rdata is sampled in that same cycle.
module axi_mem_slave #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 1,
    parameter int LEN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_W-1:0]       s_axi_awid,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [LEN_W-1:0]      s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_W-1:0]       s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_W-1:0]       s_axi_arid,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [LEN_W-1:0]      s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_W-1:0]       s_axi_rid,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  mem_valid,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WDATA = 3'd1,
        S_WRESP = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4
    } state_t;

    localparam logic [2:0]     MAX_SIZE   = 3'($clog2(DATA_W / 8));
    localparam logic [1:0]     BURST_INCR = 2'b01;
    localparam logic [1:0]     RESP_OKAY  = 2'b00;
    localparam logic [1:0]     RESP_SLV   = 2'b10;
    localparam logic [LEN_W:0] BEAT_ONE   = 1;

    state_t              state_q, state_d;
    logic                arb_q, arb_d;          // 0: write wins a tie, 1: read wins
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic [LEN_W:0]      beat_q, beat_d;        // one extra bit so len=255 cannot wrap
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                awready_q, awready_d;
    logic                arready_q, arready_d;

    logic                take_w, take_r, w_hs, last_beat;
    logic [ADDR_W-1:0]   addr_step, next_addr;

    // Unsupported burst types and beats wider than the bus are answered with SLVERR.
    function automatic logic bad_req(input logic [1:0] burst, input logic [2:0] size);
        return burst[1] || (size > MAX_SIZE);
    endfunction

    assign s_axi_awready = awready_q;
    assign s_axi_arready = arready_q;
    assign dbg_state     = state_q;

    // Next-state, datapath updates and all channel outputs.
    always_comb begin
        state_d   = state_q;
        arb_d     = arb_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        awready_d = 1'b0;
        arready_d = 1'b0;

        s_axi_wready = 1'b0;
        s_axi_bvalid = 1'b0;
        s_axi_bid    = '0;
        s_axi_bresp  = RESP_OKAY;
        s_axi_rvalid = 1'b0;
        s_axi_rid    = '0;
        s_axi_rdata  = '0;
        s_axi_rresp  = RESP_OKAY;
        s_axi_rlast  = 1'b0;
        mem_valid    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wstrb    = '0;

        take_w    = 1'b0;
        take_r    = 1'b0;
        w_hs      = 1'b0;
        last_beat = (beat_q == {1'b0, len_q});
        addr_step = ADDR_W'(1) << size_q;
        // Errored bursts and FIXED bursts keep the address; INCR steps by the beat size.
        next_addr = (!err_q && burst_q == BURST_INCR) ? addr_q + addr_step : addr_q;

        case (state_q)
            S_IDLE: begin
                take_w = s_axi_awvalid && (!s_axi_arvalid || !arb_q);
                take_r = s_axi_arvalid && !take_w;
                if (s_axi_awvalid && s_axi_arvalid) arb_d = ~arb_q;
                // The request payload is stable while valid waits, so it is
                // latched now and ready follows one cycle later.
                if (take_w) begin
                    awready_d = 1'b1;
                    id_d      = s_axi_awid;
                    addr_d    = s_axi_awaddr;
                    len_d     = s_axi_awlen;
                    size_d    = s_axi_awsize;
                    burst_d   = s_axi_awburst;
                    beat_d    = '0;
                    err_d     = bad_req(s_axi_awburst, s_axi_awsize);
                    state_d   = S_WDATA;
                end else if (take_r) begin
                    arready_d = 1'b1;
                    id_d      = s_axi_arid;
                    addr_d    = s_axi_araddr;
                    len_d     = s_axi_arlen;
                    size_d    = s_axi_arsize;
                    burst_d   = s_axi_arburst;
                    beat_d    = '0;
                    err_d     = bad_req(s_axi_arburst, s_axi_arsize);
                    state_d   = S_RADDR;
                end
            end
            S_WDATA: begin
                mem_valid    = s_axi_wvalid && !err_q;
                mem_addr     = addr_q;
                mem_wdata    = s_axi_wdata;
                mem_wstrb    = s_axi_wstrb;
                // An errored burst is drained without touching memory.
                s_axi_wready = err_q || mem_ready;
                w_hs         = s_axi_wvalid && (err_q || mem_ready);
                if (w_hs) begin
                    beat_d = beat_q + BEAT_ONE;
                    addr_d = next_addr;
                    if (s_axi_wlast) begin
                        if (!last_beat) err_d = 1'b1;
                        state_d = S_WRESP;
                    end else if (beat_q >= {1'b0, len_q}) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WRESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bid    = id_q;
                s_axi_bresp  = err_q ? RESP_SLV : RESP_OKAY;
                if (s_axi_bready) state_d = S_IDLE;
            end
            S_RADDR: begin
                mem_valid = !err_q;
                mem_addr  = addr_q;
                if (err_q) begin
                    rdata_d = '0;
                    state_d = S_RDATA;
                end else if (mem_ready) begin
                    rdata_d = mem_rdata;
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rid    = id_q;
                s_axi_rdata  = rdata_q;
                s_axi_rresp  = err_q ? RESP_SLV : RESP_OKAY;
                s_axi_rlast  = last_beat;
                if (s_axi_rready) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d  = beat_q + BEAT_ONE;
                        addr_d  = next_addr;
                        state_d = S_RADDR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any burst in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            arb_q     <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            arb_q     <= arb_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            awready_q <= awready_d;
            arready_q <= arready_d;
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomised bench for axi_mem_slave. Driver tasks push the expected memory
// accesses and AXI responses into queues when a burst is issued; a negedge
// monitor pops and compares them whenever the DUT presents an output.
module tb_axi_mem_slave;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 1;
    localparam int LEN_W  = 8;
    localparam int STRB_W = DATA_W / 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [ID_W-1:0]   awid, arid, bid, rid;
    logic [ADDR_W-1:0] awaddr, araddr, mem_addr;
    logic [LEN_W-1:0]  awlen, arlen;
    logic [2:0]        awsize, arsize, dbg_state;
    logic [1:0]        awburst, arburst, bresp, rresp;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic [DATA_W-1:0] wdata, rdata, mem_wdata, mem_rdata;
    logic [STRB_W-1:0] wstrb, mem_wstrb;
    logic              mem_valid, mem_ready;

    // Memory model: every word reads back as its address plus one.
    assign mem_rdata = mem_addr + 32'd1;

    axi_mem_slave #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [67:0] exp_mem_q[$];     // {addr, wdata, wstrb} of each native write
    logic [31:0] exp_rdaddr_q[$];  // address of each native read
    logic [2:0]  exp_b_q[$];       // {bid, bresp}
    logic [35:0] exp_r_q[$];       // {rid, rdata, rresp, rlast}

    int aw_hs_cyc = 0;
    int ar_hs_cyc = 0;
    int r_hs_cnt  = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [127:0] got);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %h expected no activity", name, got);
    endtask

    // Monitor: compares every DUT output event against the expected queues.
    always @(negedge clk) begin
        if (rst) begin
            if (awready || arready) check("aw_ar_exclusive", awready && arready, 1'b0);
            if (awvalid && awready) aw_hs_cyc = cyc;
            if (arvalid && arready) ar_hs_cyc = cyc;
            if (mem_valid && mem_ready) begin
                if (mem_wstrb != '0) begin
                    if (exp_mem_q.size() == 0) fail_now("mem_write_unexpected", {mem_addr, mem_wdata});
                    else check("mem_write", {mem_addr, mem_wdata, mem_wstrb}, exp_mem_q.pop_front());
                end else begin
                    if (exp_rdaddr_q.size() == 0) fail_now("mem_read_unexpected", mem_addr);
                    else check("mem_read_addr", mem_addr, exp_rdaddr_q.pop_front());
                end
            end
            if (bvalid && bready) begin
                if (exp_b_q.size() == 0) fail_now("b_unexpected", {bid, bresp});
                else check("b_resp", {bid, bresp}, exp_b_q.pop_front());
            end
            if (rvalid) begin
                // Compared every valid cycle, so a stalled beat must hold steady.
                if (exp_r_q.size() == 0) fail_now("r_unexpected", {rid, rdata, rresp, rlast});
                else begin
                    check("r_beat", {rid, rdata, rresp, rlast}, exp_r_q[0]);
                    if (rready) begin
                        void'(exp_r_q.pop_front());
                        r_hs_cnt++;
                    end
                end
            end
        end
    end

    // ---------------- ready generators ----------------
    int mem_mode = 0;  // 0: always ready, 1: every other cycle, 2: random
    int rsp_mode = 0;

    initial begin
        mem_ready = 1'b1;
        bready    = 1'b1;
        rready    = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mem_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = ~mem_ready;
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
            case (rsp_mode)
                0: begin bready = 1'b1; rready = 1'b1; end
                1: begin bready = ~bready; rready = ~rready; end
                default: begin
                    bready = 1'($urandom_range(0, 1));
                    rready = 1'($urandom_range(0, 1));
                end
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    // Write burst of nb beats; expectations come from the AXI rules directly.
    task automatic do_write(input logic id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int nb,
                            input bit rnd, input logic [31:0] seed);
        logic [31:0] wd[16];
        logic [3:0]  ws[16];
        bit          err;
        int          nwr;
        int          n;
        for (int i = 0; i < nb; i++) begin
            wd[i] = rnd ? $urandom : seed + 32'(i);
            ws[i] = rnd ? 4'($urandom_range(1, 15)) : 4'hF;
        end
        err = (burst > 2'b01) || (size > 3'd2);
        nwr = (nb < len + 1) ? nb : len + 1;
        if (!err)
            for (int i = 0; i < nwr; i++)
                exp_mem_q.push_back({addr + (burst == 2'b01 ? (32'(i) << size) : 32'd0), wd[i], ws[i]});
        exp_b_q.push_back({id, (err || nb != len + 1) ? 2'b10 : 2'b00});

        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 2000);
        if (!awready) fail_now("aw_timeout", n);
        @(posedge clk); #1;
        awvalid = 1'b0;

        for (int i = 0; i < nb; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(posedge clk); #1;
            end
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == nb - 1);
            n = 0;
            do begin @(negedge clk); n++; end while (!wready && n < 2000);
            if (!wready) fail_now("w_timeout", i);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic do_read(input logic id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit          err;
        logic [31:0] a;
        int          n;
        err = (burst > 2'b01) || (size > 3'd2);
        for (int i = 0; i <= len; i++) begin
            a = addr + (burst == 2'b01 ? (32'(i) << size) : 32'd0);
            if (!err) exp_rdaddr_q.push_back(a);
            exp_r_q.push_back({id, err ? 32'd0 : a + 32'd1, err ? 2'b10 : 2'b00, i == len});
        end

        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 2000);
        if (!arready) fail_now("ar_timeout", n);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    function automatic int pending();
        return exp_mem_q.size() + exp_rdaddr_q.size() + exp_b_q.size() + exp_r_q.size();
    endfunction

    task automatic wait_done();
        int n = 0;
        while (pending() != 0 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        if (pending() != 0) begin
            fail_now("txn_timeout", pending());
            exp_mem_q.delete(); exp_rdaddr_q.delete(); exp_b_q.delete(); exp_r_q.delete();
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [127:0] all_outputs();
        return {awready, arready, wready, bvalid, bid, bresp, rvalid, rid, rdata, rresp, rlast,
                mem_valid, mem_addr, mem_wdata, mem_wstrb};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int len;
        int nb;
        logic [2:0] sz;
        logic [1:0] bt;
        int r;

        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;

        #3;
        check("reset_outputs", all_outputs(), '0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;

        // Simultaneous requests straight out of reset: write wins, then read wins.
        fork
            do_write(1'b0, 32'h10, 0, 3'd2, 2'b01, 1, 1'b1, 32'h0);
            do_read(1'b1, 32'h20, 0, 3'd2, 2'b01);
        join
        wait_done();
        check("arb_first_write", aw_hs_cyc < ar_hs_cyc, 1'b1);
        fork
            do_write(1'b1, 32'h30, 0, 3'd2, 2'b01, 1, 1'b1, 32'h0);
            do_read(1'b0, 32'h50, 0, 3'd2, 2'b01);
        join
        wait_done();
        check("arb_second_read", ar_hs_cyc < aw_hs_cyc, 1'b1);

        // Single write with echoed id.
        do_write(1'b1, 32'h40, 0, 3'd2, 2'b01, 1, 1'b0, 32'hDEADBEEF);
        wait_done();

        // Write burst with memory ready every other cycle.
        mem_mode = 1;
        do_write(1'b0, 32'h100, 3, 3'd2, 2'b01, 4, 1'b1, 32'h0);
        wait_done();
        mem_mode = 0;

        // Read burst with rready stalls.
        rsp_mode = 2;
        do_read(1'b1, 32'h200, 3, 3'd2, 2'b01);
        wait_done();

        // Protocol errors: WRAP write, oversize read, early wlast, overrun.
        do_write(1'b0, 32'h600, 3, 3'd2, 2'b10, 4, 1'b1, 32'h0);
        wait_done();
        do_read(1'b0, 32'h700, 1, 3'd3, 2'b01);
        wait_done();
        do_write(1'b1, 32'h800, 3, 3'd2, 2'b01, 2, 1'b1, 32'h0);
        wait_done();
        do_write(1'b0, 32'h900, 1, 3'd2, 2'b01, 4, 1'b1, 32'h0);
        wait_done();

        // FIXED burst and an INCR read that wraps the address space.
        do_write(1'b1, 32'h500, 2, 3'd2, 2'b00, 3, 1'b1, 32'h0);
        wait_done();
        do_read(1'b0, 32'hFFFF_FFF8, 3, 3'd2, 2'b01);
        wait_done();

        // Randomised traffic with random stalls everywhere.
        mem_mode = 2;
        for (int k = 0; k < 40; k++) begin
            len = $urandom_range(0, 7);
            r = $urandom_range(0, 9);
            sz = (r < 7) ? 3'd2 : (r == 7) ? 3'($urandom_range(0, 1)) : 3'd3;
            r = $urandom_range(0, 9);
            bt = (r < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 9);
                nb = (r == 0 && len > 0) ? len : (r == 1) ? len + 2 : len + 1;
                do_write(1'($urandom_range(0, 1)), $urandom, len, sz, bt, nb, 1'b1, 32'h0);
            end else begin
                do_read(1'($urandom_range(0, 1)), $urandom, len, sz, bt);
            end
            wait_done();
        end

        // Reset during the second beat of a len=7 read, then a clean read.
        mem_mode = 0;
        rsp_mode = 0;
        do_read(1'b1, 32'h300, 7, 3'd2, 2'b01);
        n = 0;
        r = r_hs_cnt;
        while (r_hs_cnt == r && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("reset_mid_burst_outputs", all_outputs(), '0);
        exp_r_q.delete();
        exp_rdaddr_q.delete();
        @(posedge clk); @(posedge clk); #2;
        check("reset_held_outputs", all_outputs(), '0);
        rst = 1'b1;
        do_read(1'b0, 32'h400, 0, 3'd2, 2'b01);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #900000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got time %0t expected completion", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- AXI4 slave (responder) that terminates the burst traffic issued by the team's DMA AXI master.
- Converts AXI4 read and write bursts into sequential single-word accesses on the native memory interface (valid/addr/wdata/wstrb/rdata/ready).
- Serves one transaction at a time with read/write round-robin arbitration.
- Used as the memory-side endpoint in SoC simulation and as the DDR-less on-chip memory bridge.

Parameters:
ADDR_W  32  AXI and native address width (byte address)
DATA_W  32  data width; DATA_W/8 strobe bits
ID_W    1   AXI ID width; IDs echoed back
LEN_W   8   AXI burst length width (beats = len+1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/LEN_W/3/2  write address channel payload
s_axi_awvalid in 1, s_axi_awready out 1  write address handshake
s_axi_wdata/wstrb/wlast  in  DATA_W/DATA_W/8/1  write data payload
s_axi_wvalid in 1, s_axi_wready out 1  write data handshake
s_axi_bid out ID_W, s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1  write response channel
s_axi_arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/LEN_W/3/2  read address channel payload
s_axi_arvalid in 1, s_axi_arready out 1  read address handshake
s_axi_rid out ID_W, s_axi_rdata out DATA_W, s_axi_rresp out 2, s_axi_rlast out 1, s_axi_rvalid out 1, s_axi_rready in 1  read data channel
mem_valid out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_wstrb out DATA_W/8  native request
mem_rdata in DATA_W, mem_ready in 1  native response (ready = access done, rdata valid for reads)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, arb pointer = write-first, all AXI outputs 0, mem_* outputs 0.
- Reset asserted mid-burst aborts the transaction silently; no response is issued.
- States: IDLE, WDATA, WRESP, RADDR, RDATA.
- IDLE:
  - awvalid only -> accept write. arvalid only -> accept read.
  - Both valid -> accept the direction the arb pointer selects, then toggle the pointer.
  - Accept = awready/arready high for exactly one cycle (registered). Latch id, addr, len, size, burst; clear beat counter and error flag.
  - Next state: WDATA for writes, RADDR for reads.
- Error flag is set at accept when burst is not FIXED(00) or INCR(01), or when 2^size > DATA_W/8.
- Address update per beat: INCR adds 2^size; FIXED holds the address; on error the address is held.
- WDATA:
  - mem_valid = wvalid && !err. mem_addr = current addr, mem_wdata = wdata, mem_wstrb = wstrb.
  - wready = err ? 1 : mem_ready (combinational). Each w handshake increments the beat counter and updates the address.
  - On the wlast handshake -> WRESP. Error flag is set if the beat count != len at wlast.
  - If the beat count exceeds len before wlast, set the error flag and keep accepting beats until wlast.
- WRESP: bvalid=1, bid = latched id, bresp = err ? SLVERR(10) : OKAY(00). Hold until bready, then -> IDLE.
- RADDR:
  - mem_valid=1, mem_wstrb=0, mem_addr = current addr.
  - On mem_ready, register mem_rdata into rdata -> RDATA; rvalid rises the next cycle (1-cycle latency).
  - On error, skip memory: rdata=0, go straight to RDATA.
- RDATA:
  - rvalid=1, rid = latched id, rresp = err ? SLVERR : OKAY, rlast = (beat == len).
  - rdata and rlast stay stable while rvalid && !rready.
  - On rready: if rlast -> IDLE, else increment beat, update address -> RADDR.
- Throughput: minimum 2 cycles per read beat; 1 cycle per write beat when mem_ready is held high.
- Beat counter is LEN_W+1 bits wide, so len=255 does not wrap. The address wraps modulo 2^ADDR_W.
- awready and arready are never high in the same cycle. No new address is accepted until the current response completes.

Test Plan:
- Single write: awaddr=0x40, len=0, wdata=0xDEADBEEF, wstrb=0xF, wlast=1 -> one mem write to 0x40; bvalid with bresp=00, bid echoed.
- Write burst with stalls: awaddr=0x100, len=3, size=2, INCR; mem_ready low every other cycle -> mem writes to 0x100, 0x104, 0x108, 0x10C in order; wready follows mem_ready; single bresp=00.
- Read burst: araddr=0x200, len=3, memory model returns addr+1 -> rdata 0x201, 0x205, 0x209, 0x20D; rlast only on the 4th beat; rready stalls must hold rdata stable.
- Arbitration: awvalid and arvalid raised together from reset -> write served first, then the read; second simultaneous pair -> read served first.
- Protocol errors:
  - WRAP burst (awburst=10) -> no mem_valid issued, bresp=10.
  - Read with arsize=3 on 32-bit data -> rdata=0, rresp=10.
  - wlast on beat 2 of a len=3 burst -> bresp=10.
- Reset mid-burst: drop rst to 0 during the 2nd beat of a len=7 read -> all outputs 0 immediately; after release, a new len=0 read completes normally.
